// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: follows H/V sync edges to rebuild the pixel position,
// measures line/frame length, locks on a clean frame and captures visible pixels while locked.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 795,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_VISIBLE   = 352,
  parameter int unsigned V_VISIBLE   = 288,
  parameter int unsigned HSYNC_START = 656,
  parameter int unsigned VSYNC_START = 490
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       H_SYNC_NEG,
  input  logic       V_SYNC_NEG,
  input  logic [7:0] PIXEL_COLOR_IN,
  output logic [9:0] CAP_X,
  output logic [9:0] CAP_Y,
  output logic [7:0] CAP_COLOR,
  output logic       CAP_VALID,
  output logic       FRAME_START,
  output logic       LOCKED,
  output logic       SYNC_ERROR,
  output logic [9:0] LINE_LEN,
  output logic [9:0] FRAME_LINES
);

  localparam logic [9:0] H_TOTAL_C     = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C     = 10'(V_TOTAL);
  localparam logic [9:0] H_LAST_C      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE_C   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VISIBLE_C   = 10'(V_VISIBLE);
  localparam logic [9:0] HSYNC_START_C = 10'(HSYNC_START);
  localparam logic [9:0] VSYNC_START_C = 10'(VSYNC_START);
  localparam logic [9:0] CNT_MAX_C     = 10'd1023;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t state_r;

  logic       h_prev_r;
  logic       v_prev_r;
  logic [9:0] h_pos_r;
  logic [9:0] v_pos_r;
  logic [9:0] line_cnt_r;
  logic [9:0] frame_cnt_r;
  logic       seen_h_r;
  logic       seen_v_r;
  logic       line_ok_r;

  logic       hedge_s;
  logic       vedge_s;
  logic [9:0] ex_s;
  logic [9:0] ey_s;
  logic [9:0] h_pos_nxt_s;
  logic [9:0] v_pos_nxt_s;
  logic       line_meas_s;
  logic       line_bad_s;
  logic [9:0] frame_eff_s;
  logic       frame_meas_s;
  logic       frame_bad_s;
  logic       lock_ok_s;
  logic       line_stall_s;
  logic       lose_s;
  logic       vis_s;

  // Edge detection, effective position and lock qualification for the current sample
  always_comb begin
    hedge_s = h_prev_r & ~H_SYNC_NEG;
    vedge_s = v_prev_r & ~V_SYNC_NEG;
    ex_s    = hedge_s ? HSYNC_START_C : h_pos_r;
    ey_s    = vedge_s ? VSYNC_START_C : v_pos_r;

    if (ex_s == H_LAST_C) begin
      h_pos_nxt_s = 10'd0;
      v_pos_nxt_s = (ey_s == V_LAST_C) ? 10'd0 : ey_s + 10'd1;
    end else begin
      h_pos_nxt_s = ex_s + 10'd1;
      v_pos_nxt_s = ey_s;
    end

    line_meas_s = hedge_s & seen_h_r;
    line_bad_s  = line_meas_s & (line_cnt_r != H_TOTAL_C);

    // A hedge coinciding with a vedge belongs to the frame that is closing
    if (hedge_s && (frame_cnt_r != CNT_MAX_C)) begin
      frame_eff_s = frame_cnt_r + 10'd1;
    end else begin
      frame_eff_s = frame_cnt_r;
    end

    frame_meas_s = vedge_s & seen_v_r;
    frame_bad_s  = frame_meas_s & (frame_eff_s != V_TOTAL_C);
    lock_ok_s    = frame_meas_s & ~frame_bad_s & line_ok_r & ~line_bad_s;
    line_stall_s = (line_cnt_r == CNT_MAX_C);
    lose_s       = line_bad_s | frame_bad_s | line_stall_s;
    vis_s        = LOCKED & (ex_s < H_VISIBLE_C) & (ey_s < V_VISIBLE_C);
  end

  // Sync history and predicted position of the next sample
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      h_prev_r <= 1'b0;
      v_prev_r <= 1'b0;
      h_pos_r  <= 10'd0;
      v_pos_r  <= 10'd0;
    end else begin
      h_prev_r <= H_SYNC_NEG;
      v_prev_r <= V_SYNC_NEG;
      h_pos_r  <= h_pos_nxt_s;
      v_pos_r  <= v_pos_nxt_s;
    end
  end

  // Line and frame length measurement
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      line_cnt_r  <= 10'd0;
      frame_cnt_r <= 10'd0;
      seen_h_r    <= 1'b0;
      seen_v_r    <= 1'b0;
      line_ok_r   <= 1'b0;
      LINE_LEN    <= 10'd0;
      FRAME_LINES <= 10'd0;
    end else begin
      if (hedge_s) begin
        line_cnt_r <= 10'd1;
        seen_h_r   <= 1'b1;
        if (seen_h_r) begin
          LINE_LEN <= line_cnt_r;
        end
      end else if (line_cnt_r != CNT_MAX_C) begin
        line_cnt_r <= line_cnt_r + 10'd1;
      end

      if (vedge_s) begin
        frame_cnt_r <= 10'd0;
        seen_v_r    <= 1'b1;
        line_ok_r   <= 1'b1;
        if (seen_v_r) begin
          FRAME_LINES <= frame_eff_s;
        end
      end else begin
        frame_cnt_r <= frame_eff_s;
        if (line_bad_s) begin
          line_ok_r <= 1'b0;
        end
      end
    end
  end

  // Lock state machine with registered LOCKED / SYNC_ERROR
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r    <= ST_UNLOCKED;
      LOCKED     <= 1'b0;
      SYNC_ERROR <= 1'b0;
    end else begin
      case (state_r)
        ST_UNLOCKED: begin
          SYNC_ERROR <= 1'b0;
          if (lock_ok_s) begin
            state_r <= ST_LOCKED;
            LOCKED  <= 1'b1;
          end else begin
            LOCKED  <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (lose_s) begin
            state_r    <= ST_UNLOCKED;
            LOCKED     <= 1'b0;
            SYNC_ERROR <= 1'b1;
          end else begin
            LOCKED     <= 1'b1;
            SYNC_ERROR <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_UNLOCKED;
          LOCKED     <= 1'b0;
          SYNC_ERROR <= 1'b0;
        end
      endcase
    end
  end

  // Capture of the current sample, one clock behind the input
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CAP_X       <= 10'd0;
      CAP_Y       <= 10'd0;
      CAP_COLOR   <= 8'd0;
      CAP_VALID   <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      CAP_X       <= ex_s;
      CAP_Y       <= ey_s;
      CAP_VALID   <= vis_s;
      CAP_COLOR   <= vis_s ? PIXEL_COLOR_IN : 8'd0;
      FRAME_START <= vis_s & (ex_s == 10'd0) & (ey_s == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed scenario sequence with random colour and random event placement, checked
// every cycle against a timestamp/count based model of the sync decoder.
module tb_vga_sync_decoder;

  localparam int HT  = 20;
  localparam int VT  = 12;
  localparam int HV  = 8;
  localparam int VV  = 6;
  localparam int HSS = 14;
  localparam int VSS = 9;
  localparam int HSW = 3;
  localparam int VSW = 2;
  localparam int SAT = 1023;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       H_SYNC_NEG;
  logic       V_SYNC_NEG;
  logic [7:0] PIXEL_COLOR_IN;
  logic [9:0] CAP_X;
  logic [9:0] CAP_Y;
  logic [7:0] CAP_COLOR;
  logic       CAP_VALID;
  logic       FRAME_START;
  logic       LOCKED;
  logic       SYNC_ERROR;
  logic [9:0] LINE_LEN;
  logic [9:0] FRAME_LINES;

  always #5 CLOCK = ~CLOCK;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .HSYNC_START(HSS), .VSYNC_START(VSS)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .H_SYNC_NEG(H_SYNC_NEG), .V_SYNC_NEG(V_SYNC_NEG),
    .PIXEL_COLOR_IN(PIXEL_COLOR_IN), .CAP_X(CAP_X), .CAP_Y(CAP_Y), .CAP_COLOR(CAP_COLOR),
    .CAP_VALID(CAP_VALID), .FRAME_START(FRAME_START), .LOCKED(LOCKED),
    .SYNC_ERROR(SYNC_ERROR), .LINE_LEN(LINE_LEN), .FRAME_LINES(FRAME_LINES)
  );

  int total = 0;
  int bad = 0;

  // transmitter position and stream modifiers
  int gx = 0, gy = 0, g_vtot = VT, drop_y = -1;
  bit mute = 0, hold_low = 0, rand_col = 0;

  // reference model: cycle timestamps and edge counts
  longint m_n, m_last_h;
  bit m_prev_h, m_prev_v, m_have_h, m_have_v, m_locked, m_clean;
  int m_lines, m_line_len, m_frame_lines;

  bit e_valid, e_fs, e_se, e_cmp_xy, e_vchk;
  int e_x, e_y, e_col;

  int n_valid, n_fs, n_se, max_x, max_y;
  bit saw_len40, saw_lock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_last_h = 0;
    m_prev_h = 0; m_prev_v = 0; m_have_h = 0; m_have_v = 0;
    m_locked = 0; m_clean = 0;
    m_lines = 0; m_line_len = 0; m_frame_lines = 0;
    e_valid = 0; e_fs = 0; e_se = 0; e_col = 0;
    e_cmp_xy = 1; e_vchk = 0; e_x = 0; e_y = 0;
  endtask

  task automatic model_edge(input bit hs, input bit vs, input logic [7:0] col);
    bit hedge, vedge, old_lock, lose, gain;
    longint d;
    hedge    = m_prev_h && !hs;
    vedge    = m_prev_v && !vs;
    old_lock = m_locked;
    e_valid  = old_lock && gx < HV && gy < VV;
    e_col    = e_valid ? int'(col) : 0;
    e_fs     = e_valid && gx == 0 && gy == 0;
    e_cmp_xy = old_lock;
    e_vchk   = old_lock && vedge;
    e_x = gx; e_y = gy;
    lose = 0; gain = 0;
    d = m_n - m_last_h;
    if (d > SAT) d = SAT;
    if (hedge) begin
      if (m_have_h) begin
        m_line_len = int'(d);
        if (d != HT) begin
          m_clean = 0;
          lose = 1;
        end
      end
      m_have_h = 1;
      m_last_h = m_n;
      m_lines++;
    end else if (m_have_h && d == SAT) begin
      lose = 1;
    end
    if (vedge) begin
      if (m_have_v) begin
        m_frame_lines = m_lines;
        if (m_lines != VT) lose = 1;
        else if (m_clean) gain = 1;
      end
      m_have_v = 1;
      m_lines = 0;
      m_clean = 1;
    end
    e_se = old_lock && lose;
    m_locked = old_lock ? !lose : gain;
    m_prev_h = hs;
    m_prev_v = vs;
    m_n++;
  endtask

  task automatic step(input bit rst);
    bit hs, vs;
    logic [7:0] col;
    int t;
    hs = !(gx >= HSS && gx < HSS + HSW);
    vs = !(gy >= VSS && gy < VSS + VSW);
    if (gy == drop_y) hs = 1;
    if (mute) begin hs = 1; vs = 1; end
    if (hold_low) begin hs = 0; vs = 0; end
    t = gx ^ gy;
    col = rand_col ? 8'($urandom_range(0, 255)) : t[7:0];
    RESET = rst; H_SYNC_NEG = hs; V_SYNC_NEG = vs; PIXEL_COLOR_IN = col;
    if (rst) model_reset();
    else model_edge(hs, vs, col);
    @(posedge CLOCK);
    @(negedge CLOCK);
    check("locked", 32'(LOCKED), 32'(m_locked));
    check("sync_error", 32'(SYNC_ERROR), 32'(e_se));
    check("cap_valid", 32'(CAP_VALID), 32'(e_valid));
    check("cap_color", 32'(CAP_COLOR), 32'(e_col));
    check("frame_start", 32'(FRAME_START), 32'(e_fs));
    check("line_len", 32'(LINE_LEN), 32'(m_line_len));
    check("frame_lines", 32'(FRAME_LINES), 32'(m_frame_lines));
    if (e_cmp_xy) begin
      check("cap_x", 32'(CAP_X), 32'(e_x));
      check("cap_y", 32'(CAP_Y), 32'(e_y));
    end
    if (e_vchk) begin
      check("vedge_x", 32'(CAP_X), 32'd0);
      check("vedge_y", 32'(CAP_Y), 32'(VSS));
    end
    if (CAP_VALID === 1'b1) n_valid++;
    if (FRAME_START === 1'b1) n_fs++;
    if (SYNC_ERROR === 1'b1) n_se++;
    if (LOCKED === 1'b1) begin
      saw_lock = 1;
      if (int'(CAP_X) > max_x) max_x = int'(CAP_X);
      if (int'(CAP_Y) > max_y) max_y = int'(CAP_Y);
    end
    if (LINE_LEN === 10'd40) saw_len40 = 1;
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy >= g_vtot) gy = 0;
    end
  endtask

  task automatic align();
    for (int i = 0; i < HT * (VT + 2) && !(gx == 0 && gy == 0); i++) step(0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(CAP_X), 32'd0);
    check({tag, "_y"}, 32'(CAP_Y), 32'd0);
    check({tag, "_color"}, 32'(CAP_COLOR), 32'd0);
    check({tag, "_valid"}, 32'(CAP_VALID), 32'd0);
    check({tag, "_fs"}, 32'(FRAME_START), 32'd0);
    check({tag, "_locked"}, 32'(LOCKED), 32'd0);
    check({tag, "_err"}, 32'(SYNC_ERROR), 32'd0);
    check({tag, "_len"}, 32'(LINE_LEN), 32'd0);
    check({tag, "_lines"}, 32'(FRAME_LINES), 32'd0);
  endtask

  initial begin
    // syncs held low through reset and beyond
    hold_low = 1;
    repeat (3) step(1);
    check_all_zero("reset");
    repeat (6) step(0);
    check("low_no_len", 32'(LINE_LEN), 32'd0);
    check("low_unlocked", 32'(LOCKED), 32'd0);
    hold_low = 0; gx = 0; gy = 0;

    // nominal stream, colour = x^y
    repeat (3 * HT * VT) step(0);
    check("nom_locked", 32'(LOCKED), 32'd1);
    check("nom_line_len", 32'(LINE_LEN), 32'(HT));
    check("nom_frame_lines", 32'(FRAME_LINES), 32'(VT));
    n_valid = 0; n_fs = 0; n_se = 0; max_x = -1; max_y = -1;
    repeat (HT * VT) step(0);
    check("nom_valid_count", 32'(n_valid), 32'(HV * VV));
    check("nom_frame_starts", 32'(n_fs), 32'd1);
    check("nom_max_x", 32'(max_x), 32'(HT - 1));
    check("nom_max_y", 32'(max_y), 32'(VT - 1));
    check("nom_no_error", 32'(n_se), 32'd0);

    // dropped hsync on a random line while locked
    rand_col = 1;
    align();
    drop_y = $urandom_range(1, 7);
    n_se = 0; saw_len40 = 0;
    repeat (HT * VT) step(0);
    drop_y = -1;
    check("drop_len40", 32'(saw_len40), 32'd1);
    check("drop_err_pulses", 32'(n_se), 32'd1);
    check("drop_unlocked", 32'(LOCKED), 32'd0);
    repeat (HT * VT) step(0);
    check("drop_relock", 32'(LOCKED), 32'd1);

    // all syncs stopped while locked
    n_se = 0;
    mute = 1;
    repeat (1100) step(0);
    check("mute_err_pulses", 32'(n_se), 32'd1);
    check("mute_unlocked", 32'(LOCKED), 32'd0);
    align();
    mute = 0;
    repeat (3 * HT * VT) step(0);
    check("mute_relock", 32'(LOCKED), 32'd1);

    // transmitter with one extra line per frame
    step(1); step(1);
    g_vtot = VT + 1; gx = 0; gy = 0; saw_lock = 0;
    repeat (4 * HT * (VT + 1)) step(0);
    check("long_frame_lines", 32'(FRAME_LINES), 32'(VT + 1));
    check("long_never_locked", 32'(saw_lock), 32'd0);

    // reset mid-frame while locked
    g_vtot = VT;
    step(1);
    gx = 0; gy = 0;
    repeat (3 * HT * VT) step(0);
    check("pre_rst_locked", 32'(LOCKED), 32'd1);
    repeat ($urandom_range(20, 200)) step(0);
    step(1);
    check_all_zero("midrst");
    repeat (3 * HT * VT) step(0);
    check("post_rst_relock", 32'(LOCKED), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: consumes active-low H/V sync and 8-bit pixel colour and recovers the transmitter's pixel/line position. It measures line length and lines per frame, and declares lock once a full frame matches the configured timing. While locked it emits one registered pixel per clock with coordinates, for frame-capture and self-test logic on the display link.

## Interface
- H_TOTAL, 795: clocks per line.
- V_TOTAL, 525: lines per frame.
- H_VISIBLE, 352: visible pixels per line.
- V_VISIBLE, 288: visible lines per frame.
- HSYNC_START, 656: pixel index of the first H_SYNC_NEG low sample.
- VSYNC_START, 490: line index of the first V_SYNC_NEG low sample. V_SYNC_NEG falls at pixel 0 of that line.
- CLOCK  in  1  pixel clock, same rate as the transmitter.
- RESET  in  1  synchronous, active-high reset.
- H_SYNC_NEG  in  1  active-low horizontal sync.
- V_SYNC_NEG  in  1  active-low vertical sync.
- PIXEL_COLOR_IN  in  8  pixel colour, aligned with the syncs.
- CAP_X  out  10  recovered x of the captured sample.
- CAP_Y  out  10  recovered y of the captured sample.
- CAP_COLOR  out  8  captured colour; 0 when CAP_VALID is low.
- CAP_VALID  out  1  captured sample is visible and LOCKED is high.
- FRAME_START  out  1  one-cycle pulse with the valid pixel (0,0).
- LOCKED  out  1  timing matches the parameters.
- SYNC_ERROR  out  1  one-cycle pulse when lock is lost.
- LINE_LEN  out  10  last measured clocks between H_SYNC_NEG falling edges.
- FRAME_LINES  out  10  last measured H edges between V_SYNC_NEG falling edges.

## Operation
- Edge detect: h_prev and v_prev hold the previous sample and reset to 0.
  - hedge = h_prev & ~H_SYNC_NEG; vedge = v_prev & ~V_SYNC_NEG.
  - A sync that is low at reset release is therefore not an edge.
- Position tracking: registers h_pos and v_pos hold the predicted position of the current sample.
  - Effective position: ex = hedge ? HSYNC_START : h_pos; ey = vedge ? VSYNC_START : v_pos.
  - Next h_pos = (ex == H_TOTAL-1) ? 0 : ex+1.
  - Next v_pos = (ex == H_TOTAL-1) ? ((ey == V_TOTAL-1) ? 0 : ey+1) : ey.
- Line measurement: line_cnt counts clocks and saturates at 1023.
  - On hedge: LINE_LEN <= line_cnt and line_cnt <= 1, but only if a previous hedge has been seen since reset.
  - Otherwise on hedge, line_cnt just restarts at 1.
- Frame measurement: frame_cnt counts hedges.
  - On vedge: FRAME_LINES <= frame_cnt, then frame_cnt restarts. The first vedge after reset only restarts the count.
  - line_ok clears on any measured LINE_LEN != H_TOTAL and sets at each vedge.
  - If hedge and vedge occur in the same cycle, the hedge is counted in the frame that is closing.
- Lock FSM: states UNLOCKED and LOCKED.
  - UNLOCKED -> LOCKED on a non-first vedge with frame_cnt == V_TOTAL and line_ok set.
  - LOCKED -> UNLOCKED on any of:
    - a measured LINE_LEN != H_TOTAL;
    - a vedge with frame_cnt != V_TOTAL;
    - line_cnt reaching 1023.
  - SYNC_ERROR pulses on the LOCKED -> UNLOCKED transition only.
  - Re-lock requires a new full clean frame.
- Capture outputs:
  - vis = LOCKED & ex < H_VISIBLE & ey < V_VISIBLE.
  - CAP_X <= ex; CAP_Y <= ey; CAP_VALID <= vis; CAP_COLOR <= vis ? PIXEL_COLOR_IN : 0.
  - FRAME_START <= vis & ex == 0 & ey == 0.
- All arithmetic is unsigned, 10 bits. Parameters must be at most 1023.

## Timing
- Every output is registered. RESET forces all outputs, h_pos, v_pos, the counters, h_prev, v_prev and line_ok to 0, and the FSM to UNLOCKED. RESET mid-frame discards all measurements.
- Capture latency: CAP_* and FRAME_START describe the input sample of the previous clock edge.
- LOCKED rises one clock after the qualifying vedge sample. Pixels sampled on that same edge use the old LOCKED value (0).
- LINE_LEN and FRAME_LINES update one clock after the edge sample.
- A stable transmitter gives LINE_LEN == H_TOTAL and FRAME_LINES == V_TOTAL.
- Earliest lock after reset: the second vedge, about one frame (417375 clocks at the defaults).

## Test plan
- Nominal stream from a timing generator with default parameters, colour = x[7:0]^y[7:0]:
  - LOCKED rises after the second vedge; LINE_LEN = 795; FRAME_LINES = 525.
  - Every CAP_VALID pixel has CAP_COLOR == CAP_X^CAP_Y.
  - Exactly 352*288 valid pixels per frame; one FRAME_START per frame, at (0,0).
- Short parameters (H_TOTAL=20, V_TOTAL=12, H_VISIBLE=8, V_VISIBLE=6, HSYNC_START=14, VSYNC_START=9):
  - After lock, CAP_X runs 0..19 and CAP_Y runs 0..11, with the vedge sample reported at (0,9).
- Drop one hsync pulse mid-frame while locked:
  - LINE_LEN = 40 (short parameters); one SYNC_ERROR pulse; LOCKED falls.
  - Re-lock after the next clean full frame.
- Generator using V_TOTAL+1 lines:
  - FRAME_LINES = V_TOTAL+1; LOCKED never rises.
- Syncs held low through reset and after release:
  - No edge is detected until high and then low is seen.
  - Stop all syncs while locked: SYNC_ERROR pulses when line_cnt reaches 1023.
- RESET asserted mid-frame while locked:
  - The next cycle shows all outputs 0 and LOCKED 0; lock returns after two vedges.
